// File: rtl/mvm_stream_driver.sv
// Host-side driver for an MVM engine: buffers x and A, streams them out, captures y[0..3].
// Optional WAIT_DONE watchdog is enabled by defining MVM_DRV_TIMEOUT_EN.
module mvm_stream_driver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_wr_en,
    input  logic [4:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    input  logic        go,
    output logic        busy,
    output logic        mvm_start,
    output logic [7:0]  mvm_data_in,
    input  logic        mvm_done,
    input  logic [15:0] mvm_data_out,
    input  logic [1:0]  res_addr,
    output logic [15:0] res_data,
    output logic        res_valid,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, START, STREAM, WAIT_DONE, CAPTURE, DONE, ERR
    } state_t;

    localparam int NUM_WORDS = 20;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        done_prev_q;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_buf_q [4];
    logic [15:0] res_buf_d [4];
    logic [7:0]  buf_q [NUM_WORDS];
    logic [7:0]  buf_d [NUM_WORDS];

`ifdef MVM_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        start_d     = 1'b0;
        data_d      = 8'd0;
        res_valid_d = res_valid_q;
        res_buf_d   = res_buf_q;
        buf_d       = buf_q;
`ifdef MVM_DRV_TIMEOUT_EN
        tmo_d       = tmo_q;
        err_d       = err_q;
`endif

        // Host writes are blocked while a transaction owns the operand buffer.
        if (cfg_wr_en && !busy_q && cfg_addr <= 5'd19) begin
            buf_d[cfg_addr] = cfg_data;
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_d     = START;
                    busy_d      = 1'b1;
                    start_d     = 1'b1;
                    res_valid_d = 1'b0;
`ifdef MVM_DRV_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            START: begin
                state_d = STREAM;
                cnt_d   = 5'd0;
                data_d  = buf_q[0];
            end
            STREAM: begin
                if (cnt_q == 5'd19) begin
                    state_d = WAIT_DONE;
                    cnt_d   = 5'd0;
`ifdef MVM_DRV_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d  = cnt_q + 5'd1;
                    data_d = buf_q[cnt_q + 5'd1];
                end
            end
            WAIT_DONE: begin
                // Only a fresh rising edge counts; a stale high level is ignored.
                if (mvm_done && !done_prev_q) begin
                    state_d = CAPTURE;
                    cnt_d   = 5'd0;
                end
`ifdef MVM_DRV_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ERR;
                    busy_d      = 1'b0;
                    err_d       = 1'b1;
                    res_valid_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            CAPTURE: begin
                res_buf_d[cnt_q[1:0]] = mvm_data_out;
                if (cnt_q == 5'd3) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b1;
                    cnt_d       = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= 8'd0;
            done_prev_q <= 1'b0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) res_buf_q[i] <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            data_q      <= data_d;
            done_prev_q <= mvm_done;
            res_valid_q <= res_valid_d;
            res_buf_q   <= res_buf_d;
        end
    end

    // NOTE: the operand buffer has no reset so host-loaded operands survive a reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

`ifdef MVM_DRV_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy        = busy_q;
    assign mvm_start   = start_q;
    assign mvm_data_in = data_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_buf_q[res_addr];

endmodule

// File: doc/mvm_stream_driver.md
MVM_STREAM_DRIVER -- requirements
Module: mvm_stream_driver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 64, maximum number of cycles spent in WAIT_DONE before the error exit (used only with MVM_DRV_TIMEOUT_EN).
REQ-002 Port: clk  in  1  single clock; all state changes on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: cfg_wr_en  in  1  host write strobe into the 20-entry operand buffer.
REQ-005 Port: cfg_addr  in  5  operand index; 0-3 = x[0..3], 4-19 = A row-major (A[r][c] at 4+4r+c).
REQ-006 Port: cfg_data  in  8  signed operand value.
REQ-007 Port: go  in  1  request one full matrix-vector transaction.
REQ-008 Port: busy  out  1  high from go acceptance until the DONE or ERR state is reached.
REQ-009 Port: mvm_start  out  1  start pulse to the MVM engine.
REQ-010 Port: mvm_data_in  out  8  signed operand stream to the MVM engine.
REQ-011 Port: mvm_done  in  1  completion strobe from the MVM engine.
REQ-012 Port: mvm_data_out  in  16  signed result stream from the MVM engine.
REQ-013 Port: res_addr  in  2  result read index.
REQ-014 Port: res_data  out  16  combinational read of result buffer entry res_addr.
REQ-015 Port: res_valid  out  1  result buffer holds a complete transaction.
REQ-016 Port: err  out  1  the last transaction timed out.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, START, STREAM, WAIT_DONE, CAPTURE, DONE, ERR.
REQ-018 IDLE/DONE/ERR, go sampled high -> START; res_valid and err cleared at that edge; busy=1.
REQ-019 START lasts 1 cycle with mvm_start=1; every other state drives mvm_start=0.
REQ-020 STREAM lasts exactly 20 cycles; in STREAM cycle k (k=0..19) mvm_data_in=buf[k]; the first word is presented in the cycle immediately after the mvm_start cycle.
REQ-021 Outside STREAM, mvm_data_in SHALL be 0; mvm_start and mvm_data_in are driven from registers.
REQ-022 WAIT_DONE exits on a rising edge of mvm_done (high now, low on the previous edge); a level held high from an earlier transaction SHALL NOT be accepted.
REQ-023 If the done rising edge is sampled at edge E, then y[k] = mvm_data_out SHALL be captured at edge E+1+k (k=0..3) into res_buf[k] (CAPTURE, 4 cycles).
REQ-024 After the 4th capture -> DONE: res_valid=1, busy=0; res_valid holds until the next go is accepted.
REQ-025 cfg_wr_en writes buf[cfg_addr]; it is ignored when busy=1 or cfg_addr>19.
REQ-026 A cfg write and go on the same edge in IDLE: the write SHALL be committed, and the stream SHALL carry the new value.
REQ-027 go while busy=1 SHALL be ignored, with no queuing.
REQ-028 No arithmetic is performed; results are stored bit-exact as 16-bit signed values.

Reset
REQ-029 Reset SHALL asynchronously force: state=IDLE, busy=0, mvm_start=0, mvm_data_in=0, res_valid=0, err=0, all res_buf entries=0, all counters=0.
REQ-030 The operand buffer is not reset; its contents are retained across reset.
REQ-031 Reset mid-transaction SHALL abort with no further mvm_start or data words; the next go restarts from word 0.

Configuration
REQ-032 With MVM_DRV_TIMEOUT_EN defined: WAIT_DONE counts cycles; if TIMEOUT_CYCLES elapse with no done rising edge, the FSM goes to ERR with err=1, busy=0, res_valid=0; go from ERR starts a new transaction.
REQ-033 Without MVM_DRV_TIMEOUT_EN: there is no counter, WAIT_DONE waits indefinitely, and err is tied to 0.

Verification
REQ-034 Load buf[i]=i (i=0..19), go, connected to the MVM engine -> one start pulse, stream 0..19, res_buf = 38, 62, 86, 110, res_valid=1.
REQ-035 Reload buf[i]=10+i, go again without reset -> res_buf = 718, 902, 1086, 1270; res_valid drops at go and rises after capture.
REQ-036 Behavioral engine holding mvm_done high from the previous run -> driver waits for the new rising edge; captures are not taken early.
REQ-037 MVM_DRV_TIMEOUT_EN defined, engine never asserts done -> err=1 exactly 64 cycles after WAIT_DONE entry, busy=0; next go clears err.
REQ-038 go pulsed during STREAM, plus cfg write to addr 5 during STREAM -> no second start; buf[5] unchanged.
REQ-039 Reset asserted in STREAM cycle 7 -> mvm_start=0 and mvm_data_in=0 immediately; outputs at reset values; a subsequent go streams from word 0.
